// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl: exception/interrupt controller for the single-cycle MIPS32 core.
// Rev 1.0 - fixed-priority arbitration, edge/level IRQs, sticky W1C pending, EPC/Cause.
`default_nettype none

module exc_irq_ctrl #(
  parameter int                   WIDTH      = 32,
  parameter int                   NEXC       = 2,
  parameter int                   NIRQ       = 3,
  parameter logic [NIRQ-1:0]      EDGE_MASK  = 3'b001,
  parameter logic [NIRQ-1:0]      MASK_RESET = 3'b111,
  parameter logic [WIDTH-1:0]     VECTOR     = 32'h8000_0008,
  parameter logic [WIDTH-1:0]     EPC_RESET  = 32'h8000_0000
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] pc,
  input  logic [NEXC-1:0]  exc,
  input  logic [NIRQ-1:0]  irq_src,
  input  logic             mask_we,
  input  logic [NIRQ-1:0]  mask_wd,
  input  logic             clr_we,
  input  logic [NIRQ-1:0]  clr_wd,
  output logic             take,
  output logic [WIDTH-1:0] vector,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] cause,
  output logic [NIRQ-1:0]  mask,
  output logic [NIRQ-1:0]  pending
);

  localparam int NSRC = NEXC + NIRQ;

  logic [NIRQ-1:0]  prev_irq;
  logic [NIRQ-1:0]  set_irq;
  logic [NIRQ-1:0]  eff_pend;
  logic [NIRQ-1:0]  live_irq;
  logic [NIRQ-1:0]  win_irq;
  logic [NIRQ-1:0]  auto_clr;
  logic [NIRQ-1:0]  clr_bits;
  logic [NIRQ-1:0]  pend_next;
  logic             exc_hit;
  logic             irq_hit;
  logic             found;
  logic [7:0]       win_code;
  logic [WIDTH-1:0] cause_next;

  // An arriving event is visible to arbitration in the same cycle it is set.
  always_comb begin
    set_irq  = (irq_src & ~prev_irq & EDGE_MASK) | (irq_src & ~EDGE_MASK);
    eff_pend = pending | set_irq;
    live_irq = eff_pend & mask;
    exc_hit  = |exc;
    irq_hit  = (|live_irq) & ~pc[WIDTH-1];
    take     = exc_hit | irq_hit;
    vector   = take ? VECTOR : '0;
  end

  always_comb begin
    found    = 1'b0;
    win_code = '0;
    win_irq  = '0;
    for (int i = 0; i < NEXC; i++) begin
      if (!found && exc[i]) begin
        win_code = 8'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NIRQ; i++) begin
      if (!found && live_irq[i]) begin
        win_code   = 8'(NEXC + i);
        found      = 1'b1;
        win_irq[i] = irq_hit;
      end
    end
  end

  // Taking an edge line consumes its event; a level line re-pends while its source is high.
  always_comb begin
    auto_clr  = win_irq & EDGE_MASK;
    clr_bits  = clr_we ? clr_wd : '0;
    pend_next = (set_irq | (pending & ~clr_bits)) & ~auto_clr;

    cause_next              = '0;
    cause_next[NSRC-1:0]    = {live_irq, exc};
    cause_next[15:8]        = win_code;
  end

  always_ff @(posedge C) begin
    if (!R) begin
      mask     <= MASK_RESET;
      pending  <= '0;
      prev_irq <= '0;
      epc      <= EPC_RESET;
      cause    <= '0;
    end else begin
      prev_irq <= irq_src;
      pending  <= pend_next;
      if (mask_we) begin
        mask <= mask_wd;
      end
      if (take) begin
        epc   <= pc;
        cause <= cause_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exc_irq_ctrl.sv
// tb_exc_irq_ctrl: directed and randomized checks of exc_irq_ctrl against a rule-level model.
`default_nettype none

module tb_exc_irq_ctrl;

  localparam logic [2:0]  EDGE  = 3'b001;
  localparam logic [31:0] VEC   = 32'h8000_0008;
  localparam logic [31:0] EPC_R = 32'h8000_0000;
  localparam logic [31:0] KPC   = 32'h8000_0100;

  logic        C = 1'b0;
  logic        R;
  logic [31:0] pc;
  logic [1:0]  exc;
  logic [2:0]  irq_src;
  logic        mask_we;
  logic [2:0]  mask_wd;
  logic        clr_we;
  logic [2:0]  clr_wd;
  logic        take;
  logic [31:0] vector;
  logic [31:0] epc;
  logic [31:0] cause;
  logic [2:0]  mask;
  logic [2:0]  pending;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0]  m_mask, m_pend, m_prev;
  logic [31:0] m_epc, m_cause;

  exc_irq_ctrl dut (
    .C(C), .R(R), .pc(pc), .exc(exc), .irq_src(irq_src),
    .mask_we(mask_we), .mask_wd(mask_wd), .clr_we(clr_we), .clr_wd(clr_wd),
    .take(take), .vector(vector), .epc(epc), .cause(cause),
    .mask(mask), .pending(pending)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".epc"},     epc,            m_epc);
    chk({tag, ".cause"},   cause,          m_cause);
    chk({tag, ".mask"},    {29'd0, mask},  {29'd0, m_mask});
    chk({tag, ".pending"}, {29'd0, pending}, {29'd0, m_pend});
  endtask

  // One clock cycle: drive, check same-cycle redirect, advance model, check state.
  task automatic step(input string tag, input logic r_i, input logic [31:0] pc_i,
                      input logic [1:0] exc_i, input logic [2:0] irq_i,
                      input logic mwe, input logic [2:0] mwd,
                      input logic cwe, input logic [2:0] cwd);
    bit          setb [3];
    bit          live [3];
    int          win;
    int          snap;
    bit          any_live;
    bit          exp_take;
    logic [2:0]  n_pend;
    R = r_i; pc = pc_i; exc = exc_i; irq_src = irq_i;
    mask_we = mwe; mask_wd = mwd; clr_we = cwe; clr_wd = cwd;
    any_live = 0;
    for (int i = 0; i < 3; i++) begin
      setb[i] = EDGE[i] ? (irq_i[i] && !m_prev[i]) : irq_i[i];
      live[i] = (m_pend[i] || setb[i]) && m_mask[i];
      if (live[i]) any_live = 1;
    end
    exp_take = (exc_i != 2'b00) || (any_live && !pc_i[31]);
    win = -1;
    for (int j = 0; j < 2; j++) if (win < 0 && exc_i[j]) win = j;
    for (int i = 0; i < 3; i++) if (win < 0 && live[i]) win = 2 + i;
    snap = 0;
    for (int j = 0; j < 2; j++) if (exc_i[j]) snap += (1 << j);
    for (int i = 0; i < 3; i++) if (live[i]) snap += (1 << (2 + i));
    #2;
    chk({tag, ".take"},   {31'd0, take}, {31'd0, exp_take});
    chk({tag, ".vector"}, vector, exp_take ? VEC : 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (setb[i])                 n_pend[i] = 1'b1;
      else if (cwe && cwd[i])      n_pend[i] = 1'b0;
      else                         n_pend[i] = m_pend[i];
      if (exp_take && win == 2 + i && exc_i == 2'b00 && EDGE[i]) n_pend[i] = 1'b0;
    end
    @(posedge C);
    if (!r_i) begin
      m_mask = 3'b111; m_pend = 3'b000; m_prev = 3'b000; m_epc = EPC_R; m_cause = 32'd0;
    end else begin
      m_pend = n_pend;
      m_prev = irq_i;
      if (mwe) m_mask = mwd;
      if (exp_take) begin
        m_epc   = pc_i;
        m_cause = 32'(snap) | (32'(win) << 8);
      end
    end
    #1;
    chk_state(tag);
  endtask

  initial begin
    R = 1'b0; pc = 32'd0; exc = 2'b00; irq_src = 3'b000;
    mask_we = 1'b0; mask_wd = 3'b000; clr_we = 1'b0; clr_wd = 3'b000;
    repeat (2) @(posedge C);
    #1;
    m_mask = 3'b111; m_pend = 3'b000; m_prev = 3'b000; m_epc = EPC_R; m_cause = 32'd0;

    // Reset then idle
    step("t1", 1'b1, 32'h0, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t1.epc_const",   epc,   32'h8000_0000);
    chk("t1.cause_const", cause, 32'h0);
    chk("t1.mask_const",  {29'd0, mask},    32'h7);
    chk("t1.pend_const",  {29'd0, pending}, 32'h0);

    // Synchronous exception 1 in user mode
    step("t2", 1'b1, 32'h0000_0040, 2'b10, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t2.epc_const",   epc,   32'h0000_0040);
    chk("t2.cause_const", cause, 32'h0000_0102);

    // Edge IRQ0 held off in kernel mode, taken once back in user mode
    step("t3a", 1'b1, KPC, 2'b00, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t3a.pend_const", {29'd0, pending}, 32'h1);
    step("t3b", 1'b1, KPC, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
    step("t3c", 1'b1, 32'h0000_0200, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t3c.epc_const",   epc,   32'h0000_0200);
    chk("t3c.cause_const", cause, 32'h0000_0204);
    chk("t3c.pend_const",  {29'd0, pending}, 32'h0);

    // Masked level IRQ1; unmasking uses old mask this cycle, takes next cycle
    step("t4a", 1'b1, 32'h100, 2'b00, 3'b000, 1'b1, 3'b101, 1'b0, 3'b000);
    step("t4b", 1'b1, 32'h104, 2'b00, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t4b.pend_const", {29'd0, pending}, 32'h2);
    step("t4c", 1'b1, 32'h108, 2'b00, 3'b010, 1'b1, 3'b111, 1'b0, 3'b000);
    step("t4d", 1'b1, 32'h10c, 2'b00, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t4d.code_const", {24'd0, cause[15:8]}, 32'd3);
    step("t4e", 1'b1, KPC, 2'b00, 3'b000, 1'b0, 3'b000, 1'b1, 3'b010);

    // Clear racing a new IRQ0 edge: the set survives
    step("t5a", 1'b1, KPC, 2'b00, 3'b001, 1'b0, 3'b000, 1'b1, 3'b001);
    chk("t5a.pend_const", {29'd0, pending}, 32'h1);
    step("t5b", 1'b1, KPC, 2'b00, 3'b000, 1'b0, 3'b000, 1'b1, 3'b001);
    // Exception outranks a pending IRQ1, which stays pending
    step("t5c", 1'b1, KPC, 2'b00, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000);
    step("t5d", 1'b1, 32'h300, 2'b01, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t5d.cause_const", cause, 32'h0000_0009);
    chk("t5d.pend_const",  {29'd0, pending}, 32'h2);

    // Mid-run reset, then a line held high through reset edges again
    step("t6a", 1'b1, KPC, 2'b00, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t6a.pend_const", {29'd0, pending}, 32'h7);
    step("t6b", 1'b0, KPC, 2'b00, 3'b111, 1'b1, 3'b000, 1'b0, 3'b000);
    chk("t6b.epc_const",  epc, 32'h8000_0000);
    chk("t6b.pend_const", {29'd0, pending}, 32'h0);
    chk("t6b.mask_const", {29'd0, mask},    32'h7);
    step("t6c", 1'b1, KPC, 2'b00, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t6c.pend_const", {29'd0, pending}, 32'h7);
    // Reset glitch between edges must not disturb state
    R = 1'b0; #2; R = 1'b1;
    step("t6d", 1'b1, KPC, 2'b00, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("t6d.pend_const", {29'd0, pending}, 32'h7);

    for (int k = 0; k < 400; k++) begin
      logic       r_r;
      logic [1:0] e_r;
      r_r = ($urandom_range(0, 49) != 0);
      e_r = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step("rnd", r_r, {1'($urandom_range(0, 1)), 31'($urandom)}, e_r,
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
